// File: rtl/hazard_pkg.sv
// Shared encodings and the shadow-stage record for the hazard/forwarding unit.
package hazard_pkg;

    // Operand-forwarding select encodings
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    // Default positions of the flags inside the ID control word
    localparam int LOAD_BIT_DEF  = 0;
    localparam int RF_EN_BIT_DEF = 1;

    // Register-number width and the PC alias, which is never forwarded or stalled on
    localparam int         REG_W  = 4;
    localparam logic [3:0] REG_PC = 4'd15;

    // One shadow stage: valid (writes the RF), destination, load flag
    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] dest;
        logic             load;
    } stage_t;

    localparam int STAGE_W = REG_W + 2;

endpackage

// File: rtl/hazard_forwarding_unit_shadow_pipe.sv
// Three-stage EX/MEM/WB shadow of {valid, dest, load}; shifts every cycle.
module hazard_shadow_pipe
    import hazard_pkg::*;
(
    input  logic   clk,
    input  logic   reset_n,
    input  stage_t ex_next,
    output stage_t ex,
    output stage_t mem,
    output stage_t wb
);

    stage_t ex_r;
    stage_t mem_r;
    stage_t wb_r;

    // Shift the shadow pipeline; asynchronous reset clears every stage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_r  <= '0;
            mem_r <= '0;
            wb_r  <= '0;
        end else begin
            ex_r  <= ex_next;
            mem_r <= ex_r;
            wb_r  <= mem_r;
        end
    end

    assign ex  = ex_r;
    assign mem = mem_r;
    assign wb  = wb_r;

endmodule

// File: rtl/hazard_forwarding_unit.sv
// Load-use stall, branch flush and EX operand forwarding for the 5-stage pipeline.
// Destination/load history comes from a private shadow pipeline, so no taps
// from later stages are required.
module hazard_forwarding_unit
    import hazard_pkg::*;
#(
    parameter int CTRL_W    = 23,
    parameter int LOAD_BIT  = LOAD_BIT_DEF,
    parameter int RF_EN_BIT = RF_EN_BIT_DEF,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [3:0]        id_rn,
    input  logic [3:0]        id_rm,
    input  logic [3:0]        id_rd,
    input  logic              id_use_rn,
    input  logic              id_use_rm,
    input  logic              id_use_rd,
    input  logic [3:0]        id_dest,
    input  logic              branch_taken,
    output logic              nop_signal,
    output logic              pc_le,
    output logic              if_id_le,
    output logic              if_id_flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [1:0]        fwd_c,
    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    stage_t           ex_s;
    stage_t           mem_s;
    stage_t           wb_s;
    stage_t           ex_next_s;
    logic             stall_s;
    logic [CNT_W-1:0] stall_cnt_r;
    logic             unused_bits_s;

    // Stage holds a live write to r; R15 never matches
    function automatic logic stage_match(input stage_t s, input logic [3:0] r);
        return s.v && (s.dest == r) && (r != REG_PC);
    endfunction

    // Youngest producer wins: EX, then MEM, then WB, else register file
    function automatic logic [1:0] fwd_sel(input logic use_r, input logic [3:0] r,
                                           input stage_t ex, input stage_t mem,
                                           input stage_t wb);
        logic [1:0] sel;
        if (!use_r) begin
            sel = FWD_RF;
        end else if (stage_match(ex, r)) begin
            sel = FWD_EX;
        end else if (stage_match(mem, r)) begin
            sel = FWD_MEM;
        end else if (stage_match(wb, r)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

    hazard_shadow_pipe u_shadow (
        .clk     (clk),
        .reset_n (reset_n),
        .ex_next (ex_next_s),
        .ex      (ex_s),
        .mem     (mem_s),
        .wb      (wb_s)
    );

    // Detect a load in EX feeding any read operand of the ID instruction
    always_comb begin
        stall_s = 1'b0;
        if (ex_s.load) begin
            stall_s = (stage_match(ex_s, id_rn) && id_use_rn) ||
                      (stage_match(ex_s, id_rm) && id_use_rm) ||
                      (stage_match(ex_s, id_rd) && id_use_rd);
        end else begin
            stall_s = 1'b0;
        end
    end

    // Pipeline control: a stall freezes PC/IF-ID and bubbles ID/EX; it also masks the flush
    always_comb begin
        nop_signal  = stall_s;
        pc_le       = !stall_s;
        if_id_le    = !stall_s;
        if_id_flush = branch_taken && !stall_s;
    end

    // Operand selects are always computed by the same rule, stalled or not
    always_comb begin
        fwd_a = fwd_sel(id_use_rn, id_rn, ex_s, mem_s, wb_s);
        fwd_b = fwd_sel(id_use_rm, id_rm, ex_s, mem_s, wb_s);
        fwd_c = fwd_sel(id_use_rd, id_rd, ex_s, mem_s, wb_s);
    end

    // Next EX shadow entry: the bubble clears it, which ends a stall after one cycle
    always_comb begin
        ex_next_s = '0;
        if (stall_s) begin
            ex_next_s = '0;
        end else begin
            ex_next_s.v    = id_ctrl[RF_EN_BIT];
            ex_next_s.dest = id_dest;
            ex_next_s.load = id_ctrl[LOAD_BIT];
        end
    end

    // Saturating count of stalled cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_r <= '0;
        end else if (stall_s && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_count = stall_cnt_r;

    // Control-word bits and late-stage load flags that this unit does not consume
    assign unused_bits_s = ^{id_ctrl, mem_s.load, wb_s.load};

endmodule
